// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one UART transmitter, with a tx_rdy watchdog.
// Optional packet lock is built when UART_ARB_LOCK_EN is defined.
module uart_tx_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk_50m,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_last,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic           tx_en,
  output logic [7:0]     tx_data,
  input  logic           tx_rdy,
  output logic           busy,
  output logic           err
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DROP
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [15:0]    wdog_q, wdog_d;
  logic [15:0]    wdog_inc;
  logic           tx_en_d;
  logic [7:0]     tx_data_d;
  logic [N-1:0]   gnt_d;
  logic           err_d;
  logic [N-1:0]   req_m;
  logic           hit;
  logic [PW-1:0]  win;
  logic [PW-1:0]  win_nxt;

`ifdef UART_ARB_LOCK_EN
  logic           lock_q, lock_d;
  logic [PW-1:0]  owner_q, owner_d;

  // while a packet is open only its owner may be served
  assign req_m = lock_q ? (req & (N'(1) << owner_q)) : req;
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign req_m       = req;
`endif

  assign busy     = (state_q != IDLE);
  assign wdog_inc = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
  assign win_nxt  = (win == PW'(N - 1)) ? '0 : win + PW'(1);

  // first requester at or after ptr, wrapping by compare
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!hit && req_m[idx]) begin
        hit = 1'b1;
        win = PW'(idx);
      end
    end
  end

  // next-state and output decode
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    tx_en_d   = tx_en;
    tx_data_d = tx_data;
    gnt_d     = '0;
    err_d     = err;
`ifdef UART_ARB_LOCK_EN
    lock_d    = lock_q;
    owner_d   = owner_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_rdy && hit) begin
          tx_data_d = req_data[8*win +: 8];
          gnt_d     = N'(1) << win;
          tx_en_d   = 1'b1;
          wdog_d    = '0;
          ptr_d     = win_nxt;
          state_d   = SEND;
`ifdef UART_ARB_LOCK_EN
          if (req_last[win]) begin
            lock_d  = 1'b0;
          end else begin
            lock_d  = 1'b1;
            owner_d = win;
            ptr_d   = win;
          end
`endif
        end
      end
      SEND: begin
        wdog_d = wdog_inc;
        if (!tx_rdy) begin
          tx_en_d = 1'b0;
          state_d = DROP;
        end else if (wdog_inc >= 16'(TIMEOUT)) begin
          tx_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      DROP: begin
        if (tx_rdy) state_d = IDLE;
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wdog_q  <= '0;
      tx_en   <= 1'b0;
      tx_data <= '0;
      gnt     <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      tx_en   <= tx_en_d;
      tx_data <= tx_data_d;
      gnt     <= gnt_d;
      err     <= err_d;
    end
  end

`ifdef UART_ARB_LOCK_EN
  // packet lock registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: cycle model plus directed scenarios for uart_tx_arb.
// Lock-mode expectations follow UART_ARB_LOCK_EN.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int LO = 10;

  logic           clk_50m = 1'b0;
  logic           rst_n   = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [N-1:0]   req_last = '1;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           tx_en;
  logic [7:0]     tx_data;
  logic           tx_rdy = 1'b1;
  logic           busy;
  logic           err;

  int errors = 0;
  int checks = 0;

  uart_tx_arb #(.N(N), .TIMEOUT(TO)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .req     (req),
    .req_last(req_last),
    .req_data(req_data),
    .gnt     (gnt),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_rdy  (tx_rdy),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // UART stand-in: tx_rdy low for LO cycles per accepted byte
  bit uart_dead  = 1'b0;
  bit uart_force = 1'b0;
  int low_cnt    = 0;

  initial forever begin
    @(negedge clk_50m);
    if (uart_force) begin
      tx_rdy = 1'b0;
    end else if (uart_dead) begin
      tx_rdy = 1'b1;
    end else if (low_cnt > 0) begin
      low_cnt--;
      if (low_cnt == 0) tx_rdy = 1'b1;
    end else if (tx_en && tx_rdy) begin
      tx_rdy  = 1'b0;
      low_cnt = LO;
    end else begin
      tx_rdy = 1'b1;
    end
  end

  // reference: what the outputs must be after each edge
  localparam int PH_IDLE = 0;
  localparam int PH_SEND = 1;
  localparam int PH_DROP = 2;

  int           m_phase = PH_IDLE;
  int           m_age   = 0;
  int           m_next  = 0;
  bit           m_lock  = 1'b0;
  int           m_owner = 0;
  bit           m_tx_en = 1'b0;
  logic [7:0]   m_data  = '0;
  logic [N-1:0] m_gnt   = '0;
  bit           m_err   = 1'b0;

  initial forever begin
    @(posedge clk_50m or negedge rst_n);
    if (!rst_n) begin
      m_phase = PH_IDLE;
      m_age   = 0;
      m_next  = 0;
      m_lock  = 1'b0;
      m_owner = 0;
      m_tx_en = 1'b0;
      m_data  = '0;
      m_gnt   = '0;
      m_err   = 1'b0;
    end else begin
      m_gnt = '0;
      if (m_phase == PH_IDLE) begin
        int pick;
        pick = -1;
        if (tx_rdy) begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_next + k) % N;
            if (pick < 0 && req[c] && (!m_lock || c == m_owner))
              pick = c;
          end
        end
        if (pick >= 0) begin
          m_gnt[pick] = 1'b1;
          m_data      = req_data[8*pick +: 8];
          m_tx_en     = 1'b1;
          m_age       = 0;
          m_next      = (pick + 1) % N;
          m_phase     = PH_SEND;
`ifdef UART_ARB_LOCK_EN
          if (!req_last[pick]) begin
            m_lock  = 1'b1;
            m_owner = pick;
            m_next  = pick;
          end else begin
            m_lock  = 1'b0;
          end
`endif
        end
      end else if (m_phase == PH_SEND) begin
        m_age++;
        if (!tx_rdy) begin
          m_tx_en = 1'b0;
          m_phase = PH_DROP;
        end else if (m_age >= TO) begin
          m_tx_en = 1'b0;
          m_err   = 1'b1;
          m_lock  = 1'b0;
          m_phase = PH_IDLE;
        end
      end else begin
        if (tx_rdy) m_phase = PH_IDLE;
      end
    end
  end

  // every-cycle compare against the reference
  initial forever begin
    @(negedge clk_50m);
    if (rst_n) begin
      chk("cyc tx_en", tx_en, m_tx_en);
      chk("cyc tx_data", tx_data, m_data);
      chk("cyc gnt", gnt, m_gnt);
      chk("cyc busy", busy, m_phase != PH_IDLE);
      chk("cyc err", err, m_err);
    end
  end

  task automatic wait_gnt(output int idx, output logic [7:0] d);
    bit got;
    got = 1'b0;
    idx = -1;
    d   = '0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk_50m);
      if (gnt != '0) begin
        got = 1'b1;
        d   = tx_data;
        for (int k = 0; k < N; k++) if (gnt[k]) idx = k;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_gnt: no grant within 300 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_50m);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy stuck for 300 cycles");
    end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int         idx;
    logic [7:0] d;
    int         e_i1[5] = '{0, 1, 2, 3, 0};
    int         e_d1[5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
`ifdef UART_ARB_LOCK_EN
    int         e_i6[4] = '{1, 1, 1, 0};
    int         e_d6[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
`else
    int         e_i6[4] = '{1, 0, 1, 1};
    int         e_d6[4] = '{8'hA1, 8'hB0, 8'hA2, 8'hA3};
`endif
    int         cnt1;

    repeat (3) @(negedge clk_50m);
    chk("rst tx_en", tx_en, 0);
    chk("rst gnt", gnt, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst tx_data", tx_data, 0);
    #2 rst_n = 1'b1;

    // all four requesting: strict rotation
    @(negedge clk_50m);
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    req      = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(idx, d);
      chk("rr idx", idx, e_i1[g]);
      chk("rr data", d, e_d1[g]);
      if (g == 4) req = '0;
    end
    wait_idle();

    // single request, latency and handshake edges
    req_data[8*2 +: 8] = 8'h0D;
    req = 4'b0100;
    @(negedge clk_50m);
    chk("one gnt", gnt, 4'b0100);
    chk("one tx_en", tx_en, 1);
    chk("one data", tx_data, 8'h0D);
    req = '0;
    @(negedge clk_50m);
    chk("one tx_en fall", tx_en, 0);
    chk("one busy drop", busy, 1);
    repeat (9) @(negedge clk_50m);
    chk("one busy low rdy", busy, 1);
    @(negedge clk_50m);
    chk("one busy end", busy, 0);

    // dead UART: watchdog abort after TO send cycles
    uart_dead = 1'b1;
    req_data[8*1 +: 8] = 8'h55;
    req = 4'b0010;
    @(negedge clk_50m);
    chk("wd gnt", gnt, 4'b0010);
    req = '0;
    repeat (7) @(negedge clk_50m);
    chk("wd tx_en last", tx_en, 1);
    chk("wd err before", err, 0);
    @(negedge clk_50m);
    chk("wd tx_en abort", tx_en, 0);
    chk("wd err set", err, 1);
    chk("wd busy", busy, 0);
    uart_dead = 1'b0;
    req_data[8*3 +: 8] = 8'h66;
    req = 4'b1000;
    wait_gnt(idx, d);
    chk("wd next idx", idx, 3);
    chk("wd next data", d, 8'h66);
    chk("wd err sticky", err, 1);
    req = '0;
    wait_idle();

    // tx_rdy low in idle blocks grants
    uart_force = 1'b1;
    repeat (2) @(negedge clk_50m);
    req_data[7:0] = 8'h31;
    req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_50m);
      chk("nrdy gnt", gnt, 0);
      chk("nrdy tx_en", tx_en, 0);
    end
    uart_force = 1'b0;
    wait_gnt(idx, d);
    chk("nrdy idx", idx, 0);
    chk("nrdy data", d, 8'h31);
    req = '0;
    wait_idle();

    // reset in the middle of a send
    uart_dead = 1'b1;
    req_data[8*1 +: 8] = 8'h77;
    req = 4'b0010;
    wait_gnt(idx, d);
    chk("mrst idx", idx, 1);
    req = '0;
    @(negedge clk_50m);
    chk("mrst sending", tx_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst tx_en", tx_en, 0);
    chk("mrst gnt", gnt, 0);
    chk("mrst busy", busy, 0);
    chk("mrst err", err, 0);
    chk("mrst data", tx_data, 0);
    uart_dead = 1'b0;
    @(negedge clk_50m);
    #2 rst_n = 1'b1;
    @(negedge clk_50m);
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    req = 4'b1111;
    wait_gnt(idx, d);
    chk("mrst first idx", idx, 0);
    chk("mrst first data", d, 8'h41);
    req = '0;
    wait_idle();

    // three-byte packet on 1 competing with a byte on 0
    cnt1 = 0;
    req_last = 4'b1101;
    req_data[7:0]      = 8'hB0;
    req_data[8*1 +: 8] = 8'hA1;
    req = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(idx, d);
      chk("pkt idx", idx, e_i6[g]);
      chk("pkt data", d, e_d6[g]);
      if (idx == 1) begin
        cnt1++;
        if (cnt1 == 3) begin
          req[1] = 1'b0;
        end else begin
          req_data[8*1 +: 8] = 8'hA1 + 8'(cnt1);
          req_last[1] = (cnt1 == 2);
        end
      end else if (idx == 0) begin
        req[0] = 1'b0;
      end
    end
    req = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single UART transmitter among N byte-producing requesters (greeting text generator, RX echo path, debug dumpers). Sits between the requesters and the UART's tx_en/tx_data/tx_rdy handshake, sequencing one byte at a time. Also runs a handshake watchdog, so a stuck transmitter cannot hang the requesters.

## Interface
- N, 4: number of requesters (2..8).
- TIMEOUT, 1000: clk_50m cycles allowed for tx_rdy to fall after tx_en rises (1..65535).

- clk_50m  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  req[k]=1: requester k has a byte on req_data[8k+7:8k]; held until its gnt pulse.
- req_last  in  N  req_last[k]=1: current byte ends requester k's packet (used only with UART_ARB_LOCK_EN).
- req_data  in  8*N  per-requester byte, packed.
- gnt  out  N  one-cycle one-hot pulse: byte of requester k latched into tx_data.
- tx_en  out  1  to UART: start transmission of tx_data.
- tx_data  out  8  to UART: byte to send.
- tx_rdy  in  1  from UART: 1 = transmitter idle.
- busy  out  1  1 whenever state != IDLE.
- err  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- States: IDLE, SEND, DROP.
- IDLE: when tx_rdy=1 and any req bit is set, pick winner w = first set bit scanning upward from ptr, wrapping at N-1 -> 0. Latch tx_data <= req_data[w], pulse gnt[w], tx_en <= 1, ptr <= w+1 (mod N), go to SEND. If tx_rdy=0 or req=0, stay; outputs unchanged.
- SEND: hold tx_en=1, tx_data stable. On tx_rdy=0: tx_en <= 0, go to DROP. Watchdog counter increments each SEND cycle; when it reaches TIMEOUT: tx_en <= 0, err <= 1, go to IDLE (byte dropped, gnt already given).
- DROP: wait for tx_rdy=1, then go to IDLE. The next grant can occur at the earliest one cycle after tx_rdy returns high (IDLE samples it).
- ptr width: ceil(log2 N); wrap by explicit compare, not a power-of-two mask.
- Watchdog counter: 16 bits, cleared on entry to SEND, never wraps (saturating compare).
- Requesters must not drop req before gnt; a req bit that falls before grant is simply not served.
- Simultaneous req from all N after reset: grant order 0,1,...,N-1,0,...
- A requester whose req is still high after its gnt is treated as a new byte; fairness guarantees every other pending requester is served first.

## Timing
- Reset values: state=IDLE, ptr=0, tx_en=0, tx_data=0, gnt=0, busy=0, err=0, watchdog=0, lock=0.
- Reset asserted mid-SEND: tx_en drops asynchronously; the byte in flight is abandoned; no gnt is issued.
- Grant latency: req high with tx_rdy=1 in IDLE -> gnt and tx_en registered on the next edge (1 cycle).
- tx_en stays high until the first cycle after tx_rdy is sampled low (matches UART handshake: tx_en must be seen before the UART drops tx_rdy).
- Minimum byte period: 1 (grant) + SEND cycles + DROP cycles + 1 IDLE cycle.
- gnt is never high in the same cycle as a state other than the IDLE->SEND transition.

## Configuration
- UART_ARB_LOCK_EN defined: packet lock. A grant to a byte with req_last[w]=0 sets lock with owner w. While locked, IDLE serves only the owner (other requests wait; ptr is not advanced past the owner). A granted byte with req_last=1 clears lock and sets ptr=w+1. A watchdog abort also clears lock.
- Not defined: req_last is ignored, no lock register; pure per-byte round robin.

## Test plan
- Reset, N=4, req=4'b1111, data 0x41,0x42,0x43,0x44, UART model with tx_rdy low for 10 cycles per byte -> tx_data sequence 0x41,0x42,0x43,0x44,0x41; gnt one-hot, one pulse per byte.
- Single req[2] with 0x0D, tx_rdy=1 -> gnt[2] and tx_en=1 one cycle later; tx_en falls the cycle after tx_rdy goes low; busy low again one cycle after tx_rdy returns high.
- tx_rdy held at 1 after tx_en (dead UART), TIMEOUT=8 -> tx_en falls after 8 SEND cycles, err=1 and stays 1, arbiter then serves the next request.
- req high while tx_rdy=0 in IDLE -> no gnt, tx_en stays 0 until tx_rdy=1.
- rst_n pulsed low during SEND -> tx_en=0 and all outputs at reset values immediately; after release first grant goes to requester 0.
- With UART_ARB_LOCK_EN: req[1] sends 3 bytes (last on the 3rd) while req[0] is held -> order 1,1,1,0; without the macro -> order 1,0,1,...
